// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Groups the hazard controller's pipeline-facing signals into one bundle.
//   clk and rst are not part of it; they stay plain ports on the controller.
//
//   slave  : the hazard controller (samples pipeline status, drives controls)
//   master : the pipeline side (drives status, consumes stall/flush/redirect)
//
//   Status (master -> slave):
//     dec_valid_in, dec_rs1_in, dec_rs2_in, dec_use_rs1_in, dec_use_rs2_in
//     exe_valid_in, exe_is_l_in, exe_dst_reg_in, kill_exe_in, pc_br_tk_in
//     dc_req_in, dc_hit_in, dc_fill_ack_in, ic_miss_in, ic_fill_ack_in
//   Control (slave -> master):
//     stall_if_out, stall_id_out, stall_exe_out, stall_mem_out
//     flush_id_out, flush_exe_out, pc_redirect_out, pc_redirect_addr_out
//     stall_cnt_out
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int ARCH_LEN   = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  dec_valid_in;
  logic [REG_ADDR_W-1:0] dec_rs1_in;
  logic [REG_ADDR_W-1:0] dec_rs2_in;
  logic                  dec_use_rs1_in;
  logic                  dec_use_rs2_in;
  logic                  exe_valid_in;
  logic                  exe_is_l_in;
  logic [REG_ADDR_W-1:0] exe_dst_reg_in;
  logic                  kill_exe_in;
  logic [ARCH_LEN-1:0]   pc_br_tk_in;
  logic                  dc_req_in;
  logic                  dc_hit_in;
  logic                  dc_fill_ack_in;
  logic                  ic_miss_in;
  logic                  ic_fill_ack_in;

  logic                  stall_if_out;
  logic                  stall_id_out;
  logic                  stall_exe_out;
  logic                  stall_mem_out;
  logic                  flush_id_out;
  logic                  flush_exe_out;
  logic                  pc_redirect_out;
  logic [ARCH_LEN-1:0]   pc_redirect_addr_out;
  logic [31:0]           stall_cnt_out;

  modport master (
    output dec_valid_in, dec_rs1_in, dec_rs2_in, dec_use_rs1_in, dec_use_rs2_in,
    output exe_valid_in, exe_is_l_in, exe_dst_reg_in, kill_exe_in, pc_br_tk_in,
    output dc_req_in, dc_hit_in, dc_fill_ack_in, ic_miss_in, ic_fill_ack_in,
    input  stall_if_out, stall_id_out, stall_exe_out, stall_mem_out,
    input  flush_id_out, flush_exe_out, pc_redirect_out, pc_redirect_addr_out,
    input  stall_cnt_out
  );

  modport slave (
    input  dec_valid_in, dec_rs1_in, dec_rs2_in, dec_use_rs1_in, dec_use_rs2_in,
    input  exe_valid_in, exe_is_l_in, exe_dst_reg_in, kill_exe_in, pc_br_tk_in,
    input  dc_req_in, dc_hit_in, dc_fill_ack_in, ic_miss_in, ic_fill_ack_in,
    output stall_if_out, stall_id_out, stall_exe_out, stall_mem_out,
    output flush_id_out, flush_exe_out, pc_redirect_out, pc_redirect_addr_out,
    output stall_cnt_out
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush/redirect controller for the 5-stage in-order pipeline
//   (IF, ID, EXE, MEM, WB): load-use detection, D-cache and I-cache miss
//   sequencing, and conversion of an EXE branch kill into a registered,
//   one-shot PC redirect.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous, active-high reset
//     hz   - pipeline_hazard_ctrl_if.slave (status in, stall/flush/redirect out)
//
//   Build option:
//     STALL_CNT_EN - when defined, stall_cnt_out counts cycles with
//                    stall_if_out=1 (saturating). When undefined, no counter
//                    flops exist and stall_cnt_out is tied to 0.
//
//   D-FSM states:
//     state    | meaning
//     D_IDLE   | no data-side miss outstanding
//     D_MISS   | waiting for the D-cache refill
//     D_REPLAY | MEM access re-executes and hits; pipeline released next cycle
//
//   I-FSM states:
//     state    | meaning
//     I_IDLE   | fetch running normally
//     I_MISS   | waiting for an I-cache refill on the correct path
//     I_CANCEL | refill is wrong-path (branch taken meanwhile); drop it
//
//   Priority: D stall > branch flush > I-miss > load-use.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int ARCH_LEN   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    D_IDLE   = 2'd0,
    D_MISS   = 2'd1,
    D_REPLAY = 2'd2
  } d_state_t;

  typedef enum logic [1:0] {
    I_IDLE   = 2'd0,
    I_MISS   = 2'd1,
    I_CANCEL = 2'd2
  } i_state_t;

  d_state_t d_state;
  d_state_t d_next;
  i_state_t i_state;
  i_state_t i_next;

  logic                pend_valid;
  logic [ARCH_LEN-1:0] pend_addr;

  logic dmiss;
  logic dstall;
  logic imiss;
  logic istall;
  logic kill_acc;
  logic br_flush;
  logic src_match;
  logic lu;
  logic lu_eff;
  logic redirect;

  logic stall_if;
  logic stall_id;
  logic stall_exe;
  logic stall_mem;
  logic flush_id;
  logic flush_exe;
  logic pc_redirect;

  // --------------------------------------------------------------------------
  // Hazard terms
  // --------------------------------------------------------------------------
  assign dmiss  = (d_state == D_IDLE) & hz.dc_req_in & ~hz.dc_hit_in;
  assign dstall = dmiss | (d_state != D_IDLE);

  // The EXE instruction only leaves EXE when EXE is not held, so a kill that
  // is held through a D stall is taken exactly once, on release.
  assign kill_acc = hz.kill_exe_in & ~dstall;

  // A miss seen while a redirect is pending is on the wrong path.
  assign imiss  = (i_state == I_IDLE) & hz.ic_miss_in & ~pend_valid;
  assign istall = imiss | (i_state != I_IDLE);

  assign br_flush = kill_acc | pend_valid;

  // Redirect waits for any outstanding I-refill to drain so the fetch unit
  // never sees the new PC while a line fill is still in flight.
  assign redirect = pend_valid & (i_state == I_IDLE) & ~dstall;

  assign src_match = (hz.dec_use_rs1_in & (hz.dec_rs1_in == hz.exe_dst_reg_in)) |
                     (hz.dec_use_rs2_in & (hz.dec_rs2_in == hz.exe_dst_reg_in));

  assign lu = ~dstall & hz.exe_valid_in & hz.exe_is_l_in &
              (hz.exe_dst_reg_in != '0) & hz.dec_valid_in & src_match;

  // The instruction in ID is wrong-path once a branch is taken.
  assign lu_eff = lu & ~br_flush;

  // --------------------------------------------------------------------------
  // D-cache miss FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state <= D_IDLE;
    end else begin
      d_state <= d_next;
    end
  end

  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE: begin
        if (dmiss) begin
          d_next = D_MISS;
        end
      end
      D_MISS: begin
        if (hz.dc_fill_ack_in) begin
          d_next = D_REPLAY;
        end
      end
      D_REPLAY: begin
        d_next = D_IDLE;
      end
      default: begin
        d_next = D_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // I-cache miss FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state <= I_IDLE;
    end else begin
      i_state <= i_next;
    end
  end

  // Fill acks advance this FSM even while a D stall holds the pipeline.
  always_comb begin
    i_next = i_state;
    case (i_state)
      I_IDLE: begin
        if (imiss) begin
          i_next = I_MISS;
        end
      end
      I_MISS: begin
        if (hz.ic_fill_ack_in) begin
          i_next = I_IDLE;
        end else if (kill_acc) begin
          i_next = I_CANCEL;
        end
      end
      I_CANCEL: begin
        if (hz.ic_fill_ack_in) begin
          i_next = I_IDLE;
        end
      end
      default: begin
        i_next = I_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending redirect. A kill in the same cycle as an issuing redirect keeps
  // the entry valid with the newer target.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else if (kill_acc) begin
      pend_valid <= 1'b1;
      pend_addr  <= hz.pc_br_tk_in;
    end else if (redirect) begin
      pend_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Forced low while rst is high so the pipeline sees no stall or
  // redirect even if status inputs are still active.
  // --------------------------------------------------------------------------
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_exe   = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_exe   = 1'b0;
    pc_redirect = 1'b0;
    if (!rst) begin
      stall_if    = dstall | istall | lu_eff;
      stall_id    = dstall | lu_eff;
      stall_exe   = dstall;
      stall_mem   = dstall;
      flush_id    = ~dstall & (br_flush | istall | lu_eff);
      // Replay of a held branch: keep the kill from issuing into MEM twice.
      flush_exe   = (d_state == D_REPLAY) & hz.kill_exe_in;
      pc_redirect = redirect;
    end
  end

  assign hz.stall_if_out         = stall_if;
  assign hz.stall_id_out         = stall_id;
  assign hz.stall_exe_out        = stall_exe;
  assign hz.stall_mem_out        = stall_mem;
  assign hz.flush_id_out         = flush_id;
  assign hz.flush_exe_out        = flush_exe;
  assign hz.pc_redirect_out      = pc_redirect;
  assign hz.pc_redirect_addr_out = pend_addr;

  // --------------------------------------------------------------------------
  // Stall-cycle counter
  // --------------------------------------------------------------------------
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_if && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt_out = stall_cnt;
`else
  assign hz.stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl. Each step drives inputs, pushes
//   the expected control vector to a scoreboard queue, then pops and compares
//   it against the DUT mid-cycle. The stall counter is checked against a
//   bench-side count (0 unless STALL_CNT_EN is defined).
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.ARCH_LEN(32), .REG_ADDR_W(5)) bus ();

  pipeline_hazard_ctrl #(.ARCH_LEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  typedef struct {
    string       tag;
    logic [38:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_addr = '0;
  logic [31:0] model_cnt  = '0;

  task automatic clear_inputs();
    bus.dec_valid_in   = 1'b0;
    bus.dec_rs1_in     = '0;
    bus.dec_rs2_in     = '0;
    bus.dec_use_rs1_in = 1'b0;
    bus.dec_use_rs2_in = 1'b0;
    bus.exe_valid_in   = 1'b0;
    bus.exe_is_l_in    = 1'b0;
    bus.exe_dst_reg_in = '0;
    bus.kill_exe_in    = 1'b0;
    bus.pc_br_tk_in    = '0;
    bus.dc_req_in      = 1'b0;
    bus.dc_hit_in      = 1'b0;
    bus.dc_fill_ack_in = 1'b0;
    bus.ic_miss_in     = 1'b0;
    bus.ic_fill_ack_in = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] dst, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    bus.exe_valid_in   = 1'b1;
    bus.exe_is_l_in    = 1'b1;
    bus.exe_dst_reg_in = dst;
    bus.dec_valid_in   = 1'b1;
    bus.dec_rs1_in     = rs1;
    bus.dec_use_rs1_in = u1;
    bus.dec_rs2_in     = rs2;
    bus.dec_use_rs2_in = u2;
  endtask

  // Expected order: stall_if, stall_id, stall_exe, stall_mem, flush_id,
  // flush_exe, pc_redirect; redirect address comes from the bench model.
  task automatic expect_out(input string tag, input logic sif, input logic sid,
                            input logic sexe, input logic smem, input logic fid,
                            input logic fexe, input logic red);
    sb_t e;
    e.tag = tag;
    e.exp = {sif, sid, sexe, smem, fid, fexe, red, model_addr};
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    sb_t         e;
    logic [38:0] obs;
    obs = {bus.stall_if_out, bus.stall_id_out, bus.stall_exe_out, bus.stall_mem_out,
           bus.flush_id_out, bus.flush_exe_out, bus.pc_redirect_out,
           bus.pc_redirect_addr_out};
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
      n_checks++;
      assert (bus.stall_cnt_out === model_cnt) else begin
        n_fail++;
        $error("FAIL %s_cnt: observed %0d expected %0d", e.tag, bus.stall_cnt_out, model_cnt);
      end
`ifdef STALL_CNT_EN
      if (e.exp[38] && !rst) model_cnt = model_cnt + 32'd1;
`endif
    end
  endtask

  // Inputs are driven at posedge+1; outputs sampled at posedge+5.
  task automatic step();
    #4;
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    // Status inputs active during reset must not leak to outputs.
    bus.dc_req_in   = 1'b1;
    bus.kill_exe_in = 1'b1;
    bus.ic_miss_in  = 1'b1;
    @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    step();

    rst = 1'b0;
    clear_inputs();
    expect_out("idle", 0, 0, 0, 0, 0, 0, 0);
    step();

    // Load-use on rs1
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    expect_out("lu_rs1", 1, 1, 0, 0, 1, 0, 0);
    step();
    bus.exe_valid_in = 1'b0;
    expect_out("lu_rs1_bubble", 0, 0, 0, 0, 0, 0, 0);
    step();

    // rs2 mismatch, then match; rs1 equal but not used
    set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    expect_out("lu_rs2_miss", 0, 0, 0, 0, 0, 0, 0);
    step();
    set_lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b1);
    expect_out("lu_rs2_hit", 1, 1, 0, 0, 1, 0, 0);
    step();

    // x0 destination never hazards
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    expect_out("lu_x0", 0, 0, 0, 0, 0, 0, 0);
    step();

    // Non-load in EXE
    set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    bus.exe_is_l_in = 1'b0;
    expect_out("lu_not_load", 0, 0, 0, 0, 0, 0, 0);
    step();
    clear_inputs();

    // D-miss: request at A, fill ack at A+10, release at A+12
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    bus.dc_req_in = 1'b1;
    bus.dc_hit_in = 1'b0;
    expect_out("dmiss_start", 1, 1, 1, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 9; i++) begin
      expect_out("dmiss_wait", 1, 1, 1, 1, 0, 0, 0);
      step();
    end
    bus.dc_fill_ack_in = 1'b1;
    expect_out("dmiss_ack", 1, 1, 1, 1, 0, 0, 0);
    step();
    bus.dc_fill_ack_in = 1'b0;
    bus.dc_hit_in      = 1'b1;
    expect_out("dmiss_replay", 1, 1, 1, 1, 0, 0, 0);
    step();
    clear_inputs();
    expect_out("dmiss_release", 0, 0, 0, 0, 0, 0, 0);
    step();

    // Branch, with a load-use present in the kill cycle (kill wins)
    set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    bus.kill_exe_in = 1'b1;
    bus.pc_br_tk_in = 32'h0000_0400;
    expect_out("br_kill", 0, 0, 0, 0, 1, 0, 0);
    step();
    model_addr = 32'h0000_0400;
    clear_inputs();
    bus.ic_miss_in = 1'b1;
    expect_out("br_redirect", 0, 0, 0, 0, 1, 0, 1);
    step();
    clear_inputs();
    expect_out("br_done", 0, 0, 0, 0, 0, 0, 0);
    step();

    // Kill held through a D-miss: one redirect, one cycle after release
    bus.dc_req_in   = 1'b1;
    bus.kill_exe_in = 1'b1;
    bus.pc_br_tk_in = 32'h0000_0800;
    expect_out("kd_start", 1, 1, 1, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      expect_out("kd_wait", 1, 1, 1, 1, 0, 0, 0);
      step();
    end
    bus.dc_fill_ack_in = 1'b1;
    expect_out("kd_ack", 1, 1, 1, 1, 0, 0, 0);
    step();
    bus.dc_fill_ack_in = 1'b0;
    bus.dc_hit_in      = 1'b1;
    expect_out("kd_replay", 1, 1, 1, 1, 0, 1, 0);
    step();
    bus.dc_req_in = 1'b0;
    bus.dc_hit_in = 1'b0;
    expect_out("kd_release", 0, 0, 0, 0, 1, 0, 0);
    step();
    model_addr = 32'h0000_0800;
    clear_inputs();
    expect_out("kd_redirect", 0, 0, 0, 0, 1, 0, 1);
    step();
    expect_out("kd_done", 0, 0, 0, 0, 0, 0, 0);
    step();

    // I-miss cancelled by a kill; second kill overwrites the target
    bus.ic_miss_in = 1'b1;
    expect_out("im_start", 1, 0, 0, 0, 1, 0, 0);
    step();
    bus.ic_miss_in = 1'b0;
    expect_out("im_wait", 1, 0, 0, 0, 1, 0, 0);
    step();
    bus.kill_exe_in = 1'b1;
    bus.pc_br_tk_in = 32'h0000_0C00;
    expect_out("im_kill", 1, 0, 0, 0, 1, 0, 0);
    step();
    model_addr = 32'h0000_0C00;
    bus.kill_exe_in = 1'b0;
    expect_out("im_cancel", 1, 0, 0, 0, 1, 0, 0);
    step();
    bus.kill_exe_in = 1'b1;
    bus.pc_br_tk_in = 32'h0000_1000;
    expect_out("im_kill2", 1, 0, 0, 0, 1, 0, 0);
    step();
    model_addr = 32'h0000_1000;
    bus.kill_exe_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_out("im_cancel2", 1, 0, 0, 0, 1, 0, 0);
      step();
    end
    bus.ic_fill_ack_in = 1'b1;
    expect_out("im_ack", 1, 0, 0, 0, 1, 0, 0);
    step();
    bus.ic_fill_ack_in = 1'b0;
    expect_out("im_redirect", 0, 0, 0, 0, 1, 0, 1);
    step();
    expect_out("im_done", 0, 0, 0, 0, 0, 0, 0);
    step();

    // Asynchronous reset while in D_MISS
    bus.dc_req_in = 1'b1;
    expect_out("rst_dmiss_start", 1, 1, 1, 1, 0, 0, 0);
    step();
    expect_out("rst_dmiss_wait", 1, 1, 1, 1, 0, 0, 0);
    step();
    rst = 1'b1;
    #1;
    model_cnt  = '0;
    model_addr = '0;
    expect_out("rst_async", 0, 0, 0, 0, 0, 0, 0);
    check_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.dc_req_in = 1'b0;
    expect_out("rst_after", 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/redirect controller for the 5-stage in-order pipeline (IF, ID, EXE, MEM, WB).
- Detects load-use hazards between ID and EXE.
- Sequences D-cache and I-cache miss stalls with two FSMs.
- Converts the execute stage's branch kill/target into a one-shot, registered PC redirect plus ID flushes.

Parameters:
- ARCH_LEN, 32, datapath and PC width (matches constants_pkg)
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- dec_valid_in  in  1  ID holds a valid instruction
- dec_rs1_in  in  REG_ADDR_W  ID source register 1
- dec_rs2_in  in  REG_ADDR_W  ID source register 2
- dec_use_rs1_in  in  1  ID reads rs1
- dec_use_rs2_in  in  1  ID reads rs2
- exe_valid_in  in  1  EXE holds a valid instruction
- exe_is_l_in  in  1  EXE instruction is a load
- exe_dst_reg_in  in  REG_ADDR_W  EXE destination register
- kill_exe_in  in  1  branch taken in EXE
- pc_br_tk_in  in  ARCH_LEN  branch target from EXE
- dc_req_in  in  1  MEM stage issues a valid load/store
- dc_hit_in  in  1  D-cache hit for dc_req_in
- dc_fill_ack_in  in  1  D-cache refill complete (1-cycle pulse)
- ic_miss_in  in  1  I-cache miss on current fetch
- ic_fill_ack_in  in  1  I-cache refill complete (1-cycle pulse)
- stall_if_out  out  1  hold PC/IF register
- stall_id_out  out  1  hold ID register
- stall_exe_out  out  1  hold EXE register
- stall_mem_out  out  1  hold MEM register
- flush_id_out  out  1  ID→EXE register loads a bubble (valid=0)
- flush_exe_out  out  1  EXE→MEM register loads a bubble
- pc_redirect_out  out  1  fetch takes pc_redirect_addr_out
- pc_redirect_addr_out  out  ARCH_LEN  redirect target
- stall_cnt_out  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - D-FSM=D_IDLE, I-FSM=I_IDLE, pend_valid=0, pend_addr=0, counter=0.
  - All outputs 0.
- dmiss = D_IDLE & dc_req_in & ~dc_hit_in.
- D-FSM: D_IDLE --dmiss--> D_MISS --dc_fill_ack_in--> D_REPLAY --(1 cycle)--> D_IDLE.
  - dstall = dmiss | (state != D_IDLE).
  - dstall forces stall_if/id/exe/mem=1 and flush_id=0.
  - D_REPLAY is the cycle the MEM access re-executes and hits; the pipeline releases the following cycle.
- Load-use: lu = ~dstall & exe_valid_in & exe_is_l_in & exe_dst_reg_in!=0 & dec_valid_in & ((dec_use_rs1_in & dec_rs1_in==exe_dst_reg_in) | (dec_use_rs2_in & dec_rs2_in==exe_dst_reg_in)).
  - lu → stall_if=stall_id=1, flush_id=1 (bubble into EXE). Combinational; lasts 1 cycle.
- Branch:
  - kill_exe_in is accepted only when stall_exe_out=0 (instruction leaving EXE). A held kill during a D stall is therefore captured exactly once.
  - Accepted kill at cycle N:
    - flush_id_out=1 at N, suppressing lu (kill wins over load-use).
    - pend_valid<=1, pend_addr<=pc_br_tk_in.
  - While pend_valid=1:
    - flush_id_out=1 unless dstall.
    - pc_redirect_out=pend_valid & I-FSM==I_IDLE & ~dstall, pc_redirect_addr_out=pend_addr.
    - pend_valid clears on the clock edge where pc_redirect_out=1.
  - Earliest redirect is N+1 (1-cycle latency).
  - A second accepted kill while pend_valid=1 overwrites pend_addr (newer branch wins).
- I-FSM: I_IDLE --ic_miss_in & ~pend_valid--> I_MISS --ic_fill_ack_in--> I_IDLE.
  - I_MISS + accepted kill → I_CANCEL (fill is wrong-path).
  - I_CANCEL --ic_fill_ack_in--> I_IDLE. The refilled line is not consumed; the pending redirect issues the next cycle.
  - ic_miss_in while pend_valid=1 is ignored (wrong-path fetch).
  - I_MISS/I_CANCEL → stall_if=1, flush_id=1 (only when not dstall).
  - Fill ack arriving during dstall still advances the I-FSM.
- Priority: dstall > branch flush > I-miss > load-use.
- stall_mem_out=1 only under dstall.
- flush_exe_out=1 only when D-FSM in D_REPLAY and a kill is held (prevents double issue). Otherwise 0.

Optional Feature:
STALL_CNT_EN
- Defined: stall_cnt_out is a 32-bit counter of cycles with stall_if_out=1. It saturates at 0xFFFFFFFF and clears on rst.
- Undefined: no counter flops; stall_cnt_out tied to 0.

Test Plan:
- Load-use: EXE lw x5 (exe_is_l=1, dst=5); ID add reads rs1=5 → stall_if=stall_id=flush_id=1 for exactly 1 cycle. The same case with dst=0 → no stall.
- D-miss: dc_req=1, dc_hit=0 at cycle 10; dc_fill_ack pulse at cycle 20 → stall_* all 1 for cycles 10–21, 0 at cycle 22.
- Branch: kill_exe=1, pc_br_tk=0x0000_0400 at cycle N → flush_id=1 at N and N+1; pc_redirect=1, addr=0x400 at N+1 only.
- Kill during D stall: kill held throughout a D-miss → exactly one redirect pulse, 1 cycle after stall release.
- I-miss cancel: ic_miss at cycle 5; kill accepted at cycle 7; fill_ack at cycle 12 → I_CANCEL; redirect at cycle 13; stall_if=1 for cycles 5–12.
- Reset mid-D_MISS: rst asserted asynchronously → all outputs 0 immediately. With STALL_CNT_EN, stall_cnt_out=0.
